// File: rtl/multicycle_controller.sv
// RV32I multicycle control FSM: decodes op/funct into datapath enables,
// mux selects, immediate format and ALU operation; traps on illegal ops.
// Ports: clk, reset (async, active-low), op, funct3, funct7b5, Zero in;
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc, ALUControl, Trap out.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Trap
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2,
    S_LUI,
    S_AUIPC,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_pcw;
  logic       w_mw;
  logic       w_irw;
  logic       w_rw;
  logic       w_trap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_ILLEGAL;
        case (op)
          OP_LOAD,
          OP_STORE: w_next = S_MEMADR;
          OP_R:     w_next = S_EXECR;
          OP_I:     w_next = S_EXECI;
          // only beq/bne are implemented
          OP_BR:    if (funct3[2:1] == 2'b00)
                      w_next = S_BRANCH;
          OP_JAL:   w_next = S_JAL;
          OP_JALR:  w_next = S_JALR1;
          OP_LUI:   w_next = S_LUI;
          OP_AUIPC: w_next = S_AUIPC;
          default:  w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LOAD) ?
                           S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR1:    w_next = S_JALR2;
      S_JALR2:    w_next = S_ALUWB;
      S_LUI:      w_next = S_FETCH;
      S_AUIPC:    w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcw     = 1'b0;
    AdrSrc    = 1'b0;
    w_mw      = 1'b0;
    w_irw     = 1'b0;
    w_rw      = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    w_aluop   = AOP_ADD;
    w_trap    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irw     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_pcw     = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        w_aluop = AOP_FN;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = AOP_FN;
      end
      S_ALUWB: w_rw = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        w_aluop = AOP_SUB;
        // funct3[0]=1 is bne
        w_pcw   = funct3[0] ? ~Zero : Zero;
      end
      S_JAL,
      S_JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        w_rw      = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_ILLEGAL: w_trap = 1'b1;
      default: ;
    endcase
  end

  // enables are gated by reset directly so they drop without a clock
  assign PCWrite  = w_pcw  & reset;
  assign MemWrite = w_mw   & reset;
  assign IRWrite  = w_irw  & reset;
  assign RegWrite = w_rw   & reset;
  assign Trap     = w_trap & reset;

  always_comb begin
    case (op)
      OP_LOAD,
      OP_I,
      OP_JALR:  ImmSrc = 3'b000;
      OP_STORE: ImmSrc = 3'b001;
      OP_BR:    ImmSrc = 3'b010;
      OP_JAL:   ImmSrc = 3'b011;
      OP_LUI,
      OP_AUIPC: ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    ALUControl = 4'b0000;
    case (w_aluop)
      AOP_SUB: ALUControl = 4'b0001;
      AOP_FN: begin
        case (funct3)
          3'b000: ALUControl = (op[5] & funct7b5) ?
                               4'b0001 : 4'b0000;
          3'b001: ALUControl = 4'b0111;
          3'b010: ALUControl = 4'b0101;
          3'b011: ALUControl = 4'b0110;
          3'b100: ALUControl = 4'b0100;
          3'b101: ALUControl = funct7b5 ?
                               4'b1001 : 4'b1000;
          3'b110: ALUControl = 4'b0011;
          3'b111: ALUControl = 4'b0010;
          default: ALUControl = 4'b0000;
        endcase
      end
      default: ALUControl = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors
// checked against hand-built expectations.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Trap;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Trap       (Trap)
  );

  logic [18:0] w_obs;
  assign w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite,
                  RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, Trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] sg(
    input logic pcw, adr, mw, irw, rw,
    input logic [1:0] rs, sa, sb,
    input logic [2:0] imm,
    input logic [3:0] alu,
    input logic trap);
    return {pcw, adr, mw, irw, rw, rs, sa, sb,
            imm, alu, trap};
  endfunction

  function automatic logic [18:0] vF(input logic [2:0] i);
    return sg(1,0,0,1,0,2'b10,2'b00,2'b10,i,4'h0,0);
  endfunction
  function automatic logic [18:0] vR(input logic [2:0] i);
    return sg(0,0,0,0,0,2'b10,2'b00,2'b10,i,4'h0,0);
  endfunction
  function automatic logic [18:0] vD(input logic [2:0] i);
    return sg(0,0,0,0,0,2'b00,2'b01,2'b01,i,4'h0,0);
  endfunction
  function automatic logic [18:0] vWB(input logic [2:0] i);
    return sg(0,0,0,0,1,2'b00,2'b00,2'b00,i,4'h0,0);
  endfunction
  function automatic logic [18:0] vJ(input logic [2:0] i);
    return sg(1,0,0,0,0,2'b00,2'b01,2'b10,i,4'h0,0);
  endfunction

  task automatic go(input logic [6:0] o,
                    input logic [2:0] f3,
                    input logic f7,
                    input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
  endtask

  task automatic cyc(input string tag,
                     input logic [18:0] exp);
    #1;
    chk(tag, {13'd0, w_obs}, {13'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    go(7'b0110011, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("rst_out", {13'd0, w_obs}, {13'd0, vR(3'b000)});
    @(negedge clk);
    reset = 1'b1;

    // add x3,x1,x2
    cyc("add_fetch", vF(3'b000));
    cyc("add_dec",   vD(3'b000));
    cyc("add_execr", sg(0,0,0,0,0,2'b00,2'b10,2'b00,
                        3'b000,4'b0000,0));
    cyc("add_aluwb", vWB(3'b000));

    // lw
    go(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc("lw_fetch",  vF(3'b000));
    cyc("lw_dec",    vD(3'b000));
    cyc("lw_madr",   sg(0,0,0,0,0,2'b00,2'b10,2'b01,
                        3'b000,4'b0000,0));
    cyc("lw_mread",  sg(0,1,0,0,0,2'b00,2'b00,2'b00,
                        3'b000,4'b0000,0));
    cyc("lw_mwb",    sg(0,0,0,0,1,2'b01,2'b00,2'b00,
                        3'b000,4'b0000,0));

    // beq, Zero=1: taken
    go(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc("beq_fetch", vF(3'b010));
    cyc("beq_dec",   vD(3'b010));
    cyc("beq_br",    sg(1,0,0,0,0,2'b00,2'b10,2'b00,
                        3'b010,4'b0001,0));

    // bne, Zero=1: not taken
    go(7'b1100011, 3'b001, 1'b0, 1'b1);
    cyc("bne_fetch", vF(3'b010));
    cyc("bne_dec",   vD(3'b010));
    cyc("bne_br",    sg(0,0,0,0,0,2'b00,2'b10,2'b00,
                        3'b010,4'b0001,0));

    // srai
    go(7'b0010011, 3'b101, 1'b1, 1'b0);
    cyc("srai_fetch", vF(3'b000));
    cyc("srai_dec",   vD(3'b000));
    cyc("srai_execi", sg(0,0,0,0,0,2'b00,2'b10,2'b01,
                         3'b000,4'b1001,0));
    cyc("srai_aluwb", vWB(3'b000));

    // sub
    go(7'b0110011, 3'b000, 1'b1, 1'b0);
    cyc("sub_fetch", vF(3'b000));
    cyc("sub_dec",   vD(3'b000));
    cyc("sub_execr", sg(0,0,0,0,0,2'b00,2'b10,2'b00,
                        3'b000,4'b0001,0));
    cyc("sub_aluwb", vWB(3'b000));

    // addi with funct7b5=1 stays add
    go(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc("addi_fetch", vF(3'b000));
    cyc("addi_dec",   vD(3'b000));
    cyc("addi_execi", sg(0,0,0,0,0,2'b00,2'b10,2'b01,
                         3'b000,4'b0000,0));
    cyc("addi_aluwb", vWB(3'b000));

    // jal
    go(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc("jal_fetch", vF(3'b011));
    cyc("jal_dec",   vD(3'b011));
    cyc("jal_jal",   vJ(3'b011));
    cyc("jal_aluwb", vWB(3'b011));

    // jalr
    go(7'b1100111, 3'b000, 1'b0, 1'b0);
    cyc("jalr_fetch", vF(3'b000));
    cyc("jalr_dec",   vD(3'b000));
    cyc("jalr_1",     sg(0,0,0,0,0,2'b00,2'b10,2'b01,
                         3'b000,4'b0000,0));
    cyc("jalr_2",     vJ(3'b000));
    cyc("jalr_aluwb", vWB(3'b000));

    // lui
    go(7'b0110111, 3'b000, 1'b0, 1'b0);
    cyc("lui_fetch", vF(3'b100));
    cyc("lui_dec",   vD(3'b100));
    cyc("lui_lui",   sg(0,0,0,0,1,2'b11,2'b00,2'b00,
                        3'b100,4'b0000,0));

    // auipc
    go(7'b0010111, 3'b000, 1'b0, 1'b0);
    cyc("auipc_fetch", vF(3'b100));
    cyc("auipc_dec",   vD(3'b100));
    cyc("auipc_auipc", vD(3'b100));
    cyc("auipc_aluwb", vWB(3'b100));

    // sw, then reset mid-MEMWRITE
    go(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("sw_fetch", vF(3'b001));
    cyc("sw_dec",   vD(3'b001));
    cyc("sw_madr",  sg(0,0,0,0,0,2'b00,2'b10,2'b01,
                       3'b001,4'b0000,0));
    #1 chk("sw_mwrite", {13'd0, w_obs},
           {13'd0, sg(0,1,1,0,0,2'b00,2'b00,2'b00,
                      3'b001,4'b0000,0)});
    #2 reset = 1'b0;
    #1 chk("sw_rst_mw", {31'd0, MemWrite}, 32'd0);
    chk("sw_rst_out", {13'd0, w_obs}, {13'd0, vR(3'b001)});
    @(negedge clk);
    reset = 1'b1;
    cyc("sw_refetch", vF(3'b001));

    // illegal op 0000000 from DECODE (FSM is in DECODE now)
    go(7'b0000000, 3'b000, 1'b0, 1'b0);
    cyc("ill_dec", vD(3'b000));
    for (int i = 0; i < 10; i++)
      cyc($sformatf("ill_hold%0d", i),
          sg(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1));
    #2 reset = 1'b0;
    #1 chk("ill_rst_trap", {31'd0, Trap}, 32'd0);
    chk("ill_rst_out", {13'd0, w_obs}, {13'd0, vR(3'b000)});
    @(negedge clk);
    reset = 1'b1;
    go(7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc("ill_refetch", vF(3'b000));
    cyc("ill_redec",   vD(3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
